// File: rtl/pipe_reg_chain.sv
// Generic valid/ready pipeline register chain with bubble collapse, per-stage flush and occupancy tracking.
// Define PIPE_REG_CHAIN_PERF_EN to implement the saturating stall/bubble performance counters.
module pipe_reg_chain #(
    parameter int unsigned DATA_W = 148,
    parameter int unsigned STAGES = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    input  logic [STAGES-1:0]                flush,
    output logic [STAGES-1:0]                stage_valid,
    output logic [$clog2(STAGES+1)-1:0]      occupancy,
    output logic [CNT_W-1:0]                 stall_cnt,
    output logic [CNT_W-1:0]                 bubble_cnt
);

    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [DATA_W-1:0] d_q [STAGES];
    logic [DATA_W-1:0] d_d [STAGES];
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;

    logic [STAGES-1:0] ve;
    logic [STAGES-1:0] en;
    logic [STAGES-1:0] up_v;
    logic [DATA_W-1:0] up_d [STAGES];
    logic              carry;
    logic              in_fire;
    logic              out_fire;

    // Ready ripples from the output back to stage 0; a running carry avoids a self-referencing vector.
    always_comb begin
        ve    = v_q & ~flush;
        en    = '0;
        carry = out_ready;
        for (int unsigned k = 0; k < STAGES; k++) begin
            carry              = ~ve[STAGES-1-k] | carry;
            en[STAGES-1-k]     = carry;
        end
    end

    always_comb begin
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int unsigned k = 1; k < STAGES; k++) begin
            up_v[k] = ve[k-1];
            up_d[k] = d_q[k-1];
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (en[k]) begin
                v_d[k] = up_v[k];
                if (up_v[k]) begin
                    d_d[k] = up_d[k];
                end
            end
        end
    end

    assign in_fire  = in_valid & en[0];
    assign out_fire = ve[STAGES-1] & out_ready;

    always_comb begin
        occ_d = OCC_W'(int'(occ_q) + int'(in_fire) - int'(out_fire) - $countones(v_q & flush));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            d_q   <= d_d;
        end
    end

    assign in_ready    = en[0];
    assign out_valid   = ve[STAGES-1];
    assign out_data    = d_q[STAGES-1];
    assign stage_valid = v_q;
    assign occupancy   = occ_q;

`ifdef PIPE_REG_CHAIN_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;
    logic [CNT_W-1:0] bubble_q;
    logic [CNT_W-1:0] bubble_d;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (out_ready && !out_valid && (bubble_q != '1)) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed scoreboard bench for pipe_reg_chain (STAGES=4, DATA_W=8, CNT_W=4); counter expectations follow PIPE_REG_CHAIN_PERF_EN.
module tb_pipe_reg_chain;

    localparam int unsigned DW = 8;
    localparam int unsigned ST = 4;
    localparam int unsigned CW = 4;
`ifdef PIPE_REG_CHAIN_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [ST-1:0] flush;
    logic [ST-1:0] stage_valid;
    logic [2:0]    occupancy;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;

    always #5 clk = ~clk;

    pipe_reg_chain #(
        .DATA_W (DW),
        .STAGES (ST),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .flush       (flush),
        .stage_valid (stage_valid),
        .occupancy   (occupancy),
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    int unsigned   checks = 0;
    int unsigned   passes = 0;
    int            cyc_n = 0;
    int            pop_cnt = 0;
    int            first_pop = 0;
    int            last_pop = 0;
    int            hs0 = 0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // One clock period: sample the output handshake mid-cycle, then step past the next edge.
    task automatic cyc();
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() > 0) begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(e));
                pop_cnt++;
                if (pop_cnt == 1) first_pop = cyc_n;
                last_pop = cyc_n;
            end else begin
                check("spurious_out", 32'(out_valid), 32'(0));
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic send(input logic [DW-1:0] x);
        in_valid = 1'b1;
        in_data  = x;
        #1;
        check("in_ready_send", 32'(in_ready), 32'(1));
        exp_q.push_back(x);
        cyc();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        flush    = '0;
        cyc();
        reset = 1'b0;
        exp_q.delete();
        pop_cnt = 0;
    endtask

    task automatic drain(input string tag, input int max);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < max; i++) begin
            if (exp_q.size() == 0) break;
            cyc();
        end
        check(tag, 32'(exp_q.size()), 32'(0));
        #1;
        check("drain_occ", 32'(occupancy), 32'(0));
        check("drain_in_ready", 32'(in_ready), 32'(1));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = '0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        check("rst_stage_valid", 32'(stage_valid), 32'(0));
        check("rst_occ", 32'(occupancy), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_stall", 32'(stall_cnt), 32'(0));
        check("rst_bubble", 32'(bubble_cnt), 32'(0));

        // Streaming 0x01..0x0A with downstream always ready
        do_reset();
        out_ready = 1'b1;
        hs0 = cyc_n;
        for (int i = 1; i <= 10; i++) begin
            if (i == 5) begin
                check("stream_bubble", 32'(bubble_cnt), PERF ? 32'(4) : 32'(0));
            end
            send(DW'(i));
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pop_cnt >= 10) break;
            cyc();
        end
        check("stream_count", 32'(pop_cnt), 32'(10));
        check("stream_latency", 32'(first_pop - hs0), 32'(4));
        check("stream_nogap", 32'(last_pop - first_pop), 32'(9));
        check("stream_stall", 32'(stall_cnt), 32'(0));

        // Back-pressure: fill, stall five cycles with a blocked input, then drain
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(DW'(8'h11 + i));
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("full_in_ready", 32'(in_ready), 32'(0));
            cyc();
        end
        in_valid = 1'b0;
        #1;
        check("full_occ", 32'(occupancy), 32'(4));
        check("full_stage_valid", 32'(stage_valid), 32'(4'hF));
        check("full_stall", 32'(stall_cnt), PERF ? 32'(5) : 32'(0));
        check("full_out_data", 32'(out_data), 32'(8'h11));
        drain("bp_drained", 12);

        // Bubble collapse: two entries separated by idle cycles under stall
        do_reset();
        out_ready = 1'b0;
        send(8'h21);
        idle(2);
        send(8'h22);
        idle(3);
        #1;
        check("collapse_stage_valid", 32'(stage_valid), 32'(4'b1100));
        check("collapse_occ", 32'(occupancy), 32'(2));
        check("collapse_out_data", 32'(out_data), 32'(8'h21));
        drain("collapse_drained", 10);

        // Selective flush of the middle stages while stalled
        do_reset();
        out_ready = 1'b0;
        send(8'h34);
        send(8'h33);
        send(8'h32);
        send(8'h31);
        flush    = 4'b0110;
        in_valid = 1'b0;
        #1;
        check("sflush_out_valid", 32'(out_valid), 32'(1));
        check("sflush_in_ready", 32'(in_ready), 32'(1));
        exp_q.delete(1);
        exp_q.delete(1);
        cyc();
        flush = '0;
        #1;
        // 0x31 advances into the freed stage 1 on the flushing edge.
        check("sflush_stage_valid", 32'(stage_valid), 32'(4'b1010));
        check("sflush_occ", 32'(occupancy), 32'(2));
        drain("sflush_drained", 10);

        // Reset in the middle of a stalled stream
        do_reset();
        out_ready = 1'b0;
        send(8'h41);
        send(8'h42);
        send(8'h43);
        idle(3);
        #1;
        check("mid_occ", 32'(occupancy), 32'(3));
        check("mid_stall", 32'(stall_cnt), PERF ? 32'(2) : 32'(0));
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        cyc();
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        check("mrst_stage_valid", 32'(stage_valid), 32'(0));
        check("mrst_occ", 32'(occupancy), 32'(0));
        check("mrst_out_data", 32'(out_data), 32'(0));
        check("mrst_out_valid", 32'(out_valid), 32'(0));
        check("mrst_in_ready", 32'(in_ready), 32'(1));
        check("mrst_stall", 32'(stall_cnt), 32'(0));
        check("mrst_bubble", 32'(bubble_cnt), 32'(0));

        // Stall counter saturation, then flushing the output stage
        do_reset();
        out_ready = 1'b0;
        send(8'h51);
        idle(24);
        #1;
        check("sat_stall", 32'(stall_cnt), PERF ? 32'(4'hF) : 32'(0));
        check("sat_out_valid", 32'(out_valid), 32'(1));
        flush = 4'b1000;
        #1;
        check("oflush_out_valid", 32'(out_valid), 32'(0));
        check("oflush_in_ready", 32'(in_ready), 32'(1));
        exp_q.delete();
        cyc();
        flush = '0;
        #1;
        check("oflush_occ", 32'(occupancy), 32'(0));
        check("oflush_stage_valid", 32'(stage_valid), 32'(0));
        check("oflush_bubble", 32'(bubble_cnt), 32'(0));

        // Full flush with a simultaneous input
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(DW'(8'h61 + i));
        flush    = 4'hF;
        in_valid = 1'b1;
        in_data  = 8'h6A;
        #1;
        check("fflush_in_ready", 32'(in_ready), 32'(1));
        check("fflush_out_valid", 32'(out_valid), 32'(0));
        exp_q.delete();
        exp_q.push_back(8'h6A);
        cyc();
        flush    = '0;
        in_valid = 1'b0;
        #1;
        check("fflush_occ", 32'(occupancy), 32'(1));
        check("fflush_stage_valid", 32'(stage_valid), 32'(4'b0001));
        drain("fflush_drained", 10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
